rr_lock_arbiter: RTL
====================

Name: rr_lock_arbiter

Overview:
- Parametrised successor to the single-cycle fixed-priority arbiter; serves N requesters with a registered one-hot grant.
- Run-time selectable policy: fixed priority (index 0 highest) or round-robin.
- Burst lock: the owner keeps the grant while it holds its request, up to MAX_HOLD cycles. After that the grant is forced to rotate if any other requester is waiting.
- Sits in front of shared single-port resources where requesters issue multi-cycle bursts.

Parameters:
- N, 32, number of requesters (>=1).
- MAX_HOLD, 8, maximum consecutive cycles one owner holds the grant while others wait (>=1).
- IDW, max(1,$clog2(N)), width of encoded grant index (derived, not overridden).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 at posedge = reset).
- rr_mode_i  in  1  0 = fixed priority, 1 = round-robin; sampled only when a new winner is chosen.
- req_i  in  N  request vector, level-sensitive.
- gnt_o  out  N  registered grant, one-hot or zero.
- gnt_id_o  out  IDW  binary index of current owner; 0 when no grant.
- gnt_valid_o  out  1  equals |gnt_o.

Behaviour:
- Reset (reset==0 at posedge): gnt_o=0, gnt_id_o=0, gnt_valid_o=0, rr pointer ptr=0, hold_cnt=0, state=IDLE. Reset overrides everything, including mid-burst.
- Latency: req_i is sampled at posedge t and the grant is visible after that edge. There is no combinational path from req_i to outputs.
- States: IDLE (no owner), GRANT (owner k, hold_cnt in 1..MAX_HOLD).
- IDLE:
  - If req_i==0, stay.
  - Otherwise pick winner w from cand=req_i, go to GRANT with owner w and hold_cnt=1.
- GRANT, owner k:
  - req_i[k]==0 (release), others requesting: re-arbitrate on the same edge with cand=req_i. The new owner is granted back-to-back with no idle bubble, and hold_cnt=1.
  - req_i[k]==0, no others requesting: go to IDLE, outputs 0.
  - req_i[k]==1, hold_cnt<MAX_HOLD: keep k, hold_cnt++.
  - req_i[k]==1, hold_cnt==MAX_HOLD, other requests present: re-arbitrate with cand=req_i & ~(1<<k), hold_cnt=1.
  - req_i[k]==1, hold_cnt==MAX_HOLD, no other requests: keep k, hold_cnt saturates at MAX_HOLD.
- Winner pick:
  - Fixed: lowest set index of cand.
  - RR: first set index of cand scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wraps).
- Pointer: on every new grant, in either mode, ptr <= (w+1) mod N. Holding a grant does not move ptr. A mode switch therefore needs no re-init.
- A rr_mode_i change during GRANT does not disturb the current owner.
- N==1: owner 0 whenever req_i[0]. The timeout never forces a change (no other requester). ptr and gnt_id_o stay 0.
- Invariant: $onehot0(gnt_o) every cycle.
- Invariant: gnt_o[i]==1 implies req_i[i] was 1 at the preceding edge.

Decomposition:
- Shared package arb_pkg: state enum (ARB_IDLE, ARB_GRANT) and a localparam helper for IDW computation.
- One sub-module arb_pick:
  - Inputs: cand[N], start[IDW], rr_en.
  - Outputs: any, win_id[IDW].
  - Purely combinational rotating priority pick. Implement as a double-width mask or loop, with no break statements.
- Top level holds the FSM, hold counter, pointer and output registers.

Test Plan (N=4, MAX_HOLD=3):
1. Reset priority: reset=0 with req_i=4'b1111 for 3 cycles -> gnt_o=0, gnt_valid_o=0. Release reset -> next edge gnt_o=4'b0001, gnt_id_o=0. Then assert reset=0 mid-burst -> gnt_o=0 on that edge, and ptr returns to 0.
2. RR rotation under full load: rr_mode_i=1, req_i=4'b1111 held -> owner sequence 0,0,0,1,1,1,2,2,2,3,3,3,0...
3. Back-to-back release: rr_mode_i=1, owner 2, req_i changes from 4'b1101 to 4'b1001 -> next edge gnt_o=4'b1000 (ptr=3), with no zero cycle between grants.
4. Fixed-mode timeout: rr_mode_i=0, req_i=4'b0011 held -> owner 0 x3, 1 x3, 0 x3. Owner 1 is never starved.
5. Lone requester saturation: req_i=4'b0100 for 10 cycles -> gnt_o=4'b0100 all 10 cycles (after 1-cycle latency), gnt_id_o=2. Then req_i=0 -> next edge gnt_o=0.
6. Mode switch mid-burst: owner 1 in fixed mode, rr_mode_i flips to 1 -> owner 1 is kept until release or timeout. The next pick starts from ptr=2, so with req_i=4'b0011 the next owner is 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and grant-index width helper for the arbiter
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  function automatic int idw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational rotating-priority pick of one candidate
module arb_pick
  import arb_pkg::*;
#(
  parameter int N = 32,
  localparam int IDW = idw_f(N)
) (
  input  logic [N-1:0]   cand,
  input  logic [IDW-1:0] start,
  input  logic           rr_en,
  output logic           any,
  output logic [IDW-1:0] win_id
);
  logic [IDW-1:0] w_base;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  assign w_base = rr_en ? start : '0;
  assign w_dbl  = {cand, cand} >> w_base;
  assign w_rot  = w_dbl[N-1:0];
  assign any    = |cand;
  // scan offsets farthest-first so the nearest set candidate is the last to assign
  always_comb begin
    logic [IDW:0] s;
    s = '0;
    win_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, w_base} + (IDW+1)'(i);
      s = (s >= (IDW+1)'(N)) ? s - (IDW+1)'(N) : s;
      if (w_rot[i]) win_id = s[IDW-1:0];
    end
  end
endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: fixed/round-robin arbiter with bounded burst lock and registered grant
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N = 32,
  parameter int MAX_HOLD = 8,
  localparam int IDW = idw_f(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rr_mode_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_valid_o
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_e     r_state;
  logic [HW-1:0]  r_hold;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_gnt;
  logic           r_valid;
  logic           w_own;
  logic           w_timeout;
  logic           w_any;
  logic           w_rearb;
  logic           w_keep;
  logic [N-1:0]   w_cand;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_ptr_nxt;
  logic [N-1:0]   w_onehot;
  assign w_own     = (r_state == ARB_GRANT) && |(req_i & r_gnt);
  assign w_timeout = r_hold == HW'(MAX_HOLD);
  assign w_cand    = w_own ? req_i & ~r_gnt : req_i;
  assign w_rearb   = w_own ? w_timeout && w_any : w_any;
  assign w_keep    = w_own && !w_rearb;
  assign w_ptr_nxt = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;
  arb_pick #(.N(N)) u_pick (
    .cand  (w_cand),
    .start (r_ptr),
    .rr_en (rr_mode_i),
    .any   (w_any),
    .win_id(w_win)
  );
  // decode the winning index into a one-hot grant vector
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N; i++) w_onehot[i] = w_win == IDW'(i);
  end
  // grant FSM: new winner, held burst with saturating counter, or release to idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_hold  <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end else if (w_rearb) begin
      r_state <= ARB_GRANT;
      r_hold  <= HW'(1);
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_win;
      r_gnt   <= w_onehot;
      r_valid <= 1'b1;
    end else if (w_keep) begin
      r_hold  <= w_timeout ? r_hold : r_hold + 1'b1;
    end else begin
      r_state <= ARB_IDLE;
      r_hold  <= '0;
      r_id    <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end
  end
  assign gnt_o       = r_gnt;
  assign gnt_id_o    = r_id;
  assign gnt_valid_o = r_valid;
endmodule
